ip_match_controller: RTL and testbench

IP_MATCH_CONTROLLER -- requirements
Module: ip_match_controller

---
 rtl/ip_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 27 ++
 rtl/ip_match_controller.sv | 122 ++++++++++++
 tb/tb_ip_match_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_ctrl_pkg.sv
// Shared types and constants for the flagged-IP match controller.
package ip_ctrl_pkg;

  localparam int FLUSH_CYCLES = 3;
  localparam int COUNT_W      = 16;
  localparam int FLUSH_W      = $clog2(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLUSH,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter
  import ip_ctrl_pkg::*;
#(
  parameter int W = COUNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ip_match_controller.sv
// Sequences one packet at a time through an external flagged-IP comparator
// and reports a match / abort result four cycles after the last word.
//
// state     | meaning
// ST_IDLE   | waiting for an accepted pkt_start
// ST_SCAN   | streaming packet words into the comparator
// ST_FLUSH  | waiting out the comparator pipeline, match sampled on last cycle
// ST_REPORT | one-cycle result pulse
module ip_match_controller
  import ip_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr_en,
  input  logic [31:0]        cfg_ip,
  input  logic               cfg_enable,
  input  logic               pkt_start,
  input  logic               pkt_valid,
  input  logic [31:0]        pkt_data,
  input  logic               pkt_end,
  input  logic               cmp_match,
  output logic               cmp_clear,
  output logic [31:0]        cmp_flagged_ip,
  output logic [31:0]        cmp_data_in,
  output logic               result_valid,
  output logic               result_match,
  output logic               result_err,
  output logic [COUNT_W-1:0] match_count,
  output logic               busy,
  output logic               drop
);

  state_e               state_q, state_d;
  logic [31:0]          shadow_ip_q, shadow_ip_d;
  logic [31:0]          active_ip_q, active_ip_d;
  logic                 abort_q, abort_d;
  logic                 match_smp_q, match_smp_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                 accept;
  logic                 report;
  logic [COUNT_W-1:0]   cnt_val;

  always_comb begin
    state_d     = state_q;
    shadow_ip_d = cfg_wr_en ? cfg_ip : shadow_ip_q;
    active_ip_d = active_ip_q;
    abort_d     = abort_q;
    match_smp_d = match_smp_q;
    flush_cnt_d = flush_cnt_q;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pkt_start && cfg_enable) begin
          accept      = 1'b1;
          // A coincident config write wins so the new IP applies immediately.
          active_ip_d = cfg_wr_en ? cfg_ip : shadow_ip_q;
          abort_d     = 1'b0;
          match_smp_d = 1'b0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!pkt_valid) begin
          abort_d     = 1'b1;
          flush_cnt_d = FLUSH_W'(FLUSH_CYCLES - 1);
          state_d     = ST_FLUSH;
        end else if (pkt_end) begin
          flush_cnt_d = FLUSH_W'(FLUSH_CYCLES - 1);
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          match_smp_d = cmp_match;
          state_d     = ST_REPORT;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_ip_q <= '0;
      active_ip_q <= '0;
      abort_q     <= 1'b0;
      match_smp_q <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_ip_q <= shadow_ip_d;
      active_ip_q <= active_ip_d;
      abort_q     <= abort_d;
      match_smp_q <= match_smp_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs are masked by rst so they read as idle during the reset cycle itself.
  assign report         = (state_q == ST_REPORT) && !rst;
  assign result_valid   = report;
  assign result_match   = report && match_smp_q && !abort_q;
  assign result_err     = report && abort_q;
  assign busy           = (state_q != ST_IDLE) && !rst;
  assign drop           = pkt_start && (state_q != ST_IDLE) && !rst;
  assign cmp_clear      = rst || accept;
  assign cmp_flagged_ip = rst ? '0 : active_ip_q;
  assign cmp_data_in    = (!rst && (state_q == ST_SCAN) && pkt_valid) ? pkt_data : '0;
  assign match_count    = rst ? '0 : cnt_val;

  sat_counter #(.W(COUNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (result_match),
    .count (cnt_val)
  );

endmodule

// File: tb/tb_ip_match_controller.sv
// Bench for ip_match_controller: byte-stream reference model plus a
// three-cycle comparator stand-in driven from the DUT's comparator port.
module tb_ip_match_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic [31:0] cfg_ip;
  logic        cfg_enable;
  logic        pkt_start;
  logic        pkt_valid;
  logic [31:0] pkt_data;
  logic        pkt_end;
  logic        cmp_match;
  logic        cmp_clear;
  logic [31:0] cmp_flagged_ip;
  logic [31:0] cmp_data_in;
  logic        result_valid;
  logic        result_match;
  logic        result_err;
  logic [15:0] match_count;
  logic        busy;
  logic        drop;

  always #5 clk = ~clk;

  ip_match_controller dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_ip         (cfg_ip),
    .cfg_enable     (cfg_enable),
    .pkt_start      (pkt_start),
    .pkt_valid      (pkt_valid),
    .pkt_data       (pkt_data),
    .pkt_end        (pkt_end),
    .cmp_match      (cmp_match),
    .cmp_clear      (cmp_clear),
    .cmp_flagged_ip (cmp_flagged_ip),
    .cmp_data_in    (cmp_data_in),
    .result_valid   (result_valid),
    .result_match   (result_match),
    .result_err     (result_err),
    .match_count    (match_count),
    .busy           (busy),
    .drop           (drop)
  );

  // Comparator stand-in: sliding two-word window, sticky hit, three-cycle latency.
  logic [31:0] win_prev = '0;
  logic        stk = 1'b0, p1 = 1'b0, p2 = 1'b0;

  function automatic logic win_hit(input logic [63:0] w, input logic [31:0] ip);
    win_hit = 1'b0;
    for (int k = 0; k <= 4; k++) if (w[63-8*k -: 32] == ip) win_hit = 1'b1;
  endfunction

  always @(posedge clk) begin
    if (cmp_clear) begin
      win_prev <= '0; stk <= 1'b0; p1 <= 1'b0; p2 <= 1'b0;
    end else begin
      win_prev <= cmp_data_in;
      stk      <= stk | win_hit({win_prev, cmp_data_in}, cmp_flagged_ip);
      p1       <= stk;
      p2       <= p1;
    end
  end
  assign cmp_match = p2;

  // Reference: does the IP appear as four consecutive bytes of the delivered words?
  function automatic logic stream_has(input logic [31:0] w0, input logic [31:0] w1,
                                      input logic [31:0] w2, input int n,
                                      input logic [31:0] ip);
    logic [7:0]  b [12];
    logic [31:0] ws [3];
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    for (int i = 0; i < 12; i++) b[i] = 8'h00;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) b[4*i+j] = ws[i][31-8*j -: 8];
    stream_has = 1'b0;
    for (int k = 0; k + 3 < 4*n; k++)
      if ({b[k], b[k+1], b[k+2], b[k+3]} == ip) stream_has = 1'b1;
  endfunction

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        chk_en = 1'b0;
  int          exp_rv_cyc = -1;
  logic        exp_match = 1'b0, exp_err = 1'b0;
  int          busy_from = -1, busy_to = -2;
  logic        exp_accept = 1'b0, exp_drop = 1'b0;
  logic [31:0] exp_data = '0, exp_ip = '0, exp_shadow = '0;
  int          model_cnt = 0;
  int          last_rv_cyc = -1;
  logic        last_match = 1'b0, last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic rv_e;
    if (chk_en) begin
      rv_e = !rst && (cyc == exp_rv_cyc);
      chk("result_valid", 32'(result_valid), 32'(rv_e));
      chk("result_match", 32'(result_match), 32'(rv_e & exp_match));
      chk("result_err", 32'(result_err), 32'(rv_e & exp_err));
      chk("busy", 32'(busy), 32'(!rst && cyc >= busy_from && cyc <= busy_to));
      chk("drop", 32'(drop), 32'(exp_drop));
      chk("cmp_clear", 32'(cmp_clear), 32'(rst | exp_accept));
      chk("cmp_data_in", cmp_data_in, exp_data);
      chk("cmp_flagged_ip", cmp_flagged_ip, rst ? 32'h0 : exp_ip);
      chk("match_count", 32'(match_count), rst ? 32'h0 : 32'(model_cnt));
      if (result_valid) begin
        last_rv_cyc = cyc; last_match = result_match; last_err = result_err;
      end
      if (rv_e && exp_match && model_cnt < 65535) model_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    pkt_start = 1'b0; pkt_valid = 1'b0; pkt_end = 1'b0; pkt_data = '0;
    cfg_wr_en = 1'b0; exp_accept = 1'b0; exp_drop = 1'b0; exp_data = '0;
  endtask

  task automatic cfg_write(input logic [31:0] v);
    step();
    cfg_wr_en = 1'b1; cfg_ip = v; exp_shadow = v;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input int gap_at, input int wr_at,
                          input logic [31:0] wr_val, input logic wr_at_start,
                          input int drop_at, output int t_last);
    logic [31:0] ws [3];
    logic [31:0] ip_used;
    logic        abort;
    int          nw;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    step();
    cfg_enable = 1'b1; pkt_start = 1'b1; exp_accept = 1'b1;
    if (wr_at_start) begin
      cfg_wr_en = 1'b1; cfg_ip = wr_val; exp_shadow = wr_val; ip_used = wr_val;
    end else begin
      ip_used = exp_shadow;
    end
    busy_from = cyc + 1; busy_to = cyc + 1000;
    abort = 1'b0; nw = n;
    for (int i = 0; i < n; i++) begin
      step();
      exp_ip = ip_used;
      if (i == gap_at) begin
        abort = 1'b1; nw = i;
        break;
      end
      pkt_valid = 1'b1; pkt_data = ws[i]; exp_data = ws[i]; pkt_end = (i == n - 1);
      if (i == wr_at) begin cfg_wr_en = 1'b1; cfg_ip = wr_val; exp_shadow = wr_val; end
      if (i == drop_at) begin pkt_start = 1'b1; exp_drop = 1'b1; end
    end
    t_last     = cyc;
    exp_match  = stream_has(w0, w1, w2, nw, ip_used) && !abort;
    exp_err    = abort;
    exp_rv_cyc = t_last + 4;
    busy_to    = t_last + 4;
    repeat (5) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_ip = '0; cfg_enable = 1'b1;
    pkt_start = 1'b0; pkt_valid = 1'b0; pkt_data = '0; pkt_end = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk); #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_clear", 32'(cmp_clear), 32'h1);
    chk("reset_count", 32'(match_count), 32'h0);
    step();
    rst = 1'b0;

    cfg_write(32'hC0A80001);
    send_pkt(3, 32'h11111111, 32'hC0A80001, 32'h22222222, -1, -1, 0, 1'b0, -1, t);
    chk("p1_latency", 32'(last_rv_cyc - t), 32'd4);
    chk("p1_match", 32'(last_match), 32'h1);
    chk("p1_count", 32'(match_count), 32'd1);

    send_pkt(2, 32'hAABBC0A8, 32'h0001CCDD, 0, -1, -1, 0, 1'b0, -1, t);
    chk("p2_shifted_match", 32'(last_match), 32'h1);
    chk("p2_count", 32'(match_count), 32'd2);

    send_pkt(2, 32'h01020304, 32'h05060708, 0, -1, -1, 0, 1'b0, -1, t);
    chk("p3_match", 32'(last_match), 32'h0);
    chk("p3_err", 32'(last_err), 32'h0);
    chk("p3_count", 32'(match_count), 32'd2);

    send_pkt(2, 32'hC0A80001, 32'h33333333, 0, 1, -1, 0, 1'b0, -1, t);
    chk("p4_gap_match", 32'(last_match), 32'h0);
    chk("p4_gap_err", 32'(last_err), 32'h1);

    step();
    cfg_enable = 1'b0; pkt_start = 1'b1;
    repeat (6) step();
    cfg_enable = 1'b1;

    send_pkt(3, 32'h11111111, 32'hC0A80001, 32'h44444444, -1, 1, 32'h0A000001, 1'b0, 2, t);
    chk("p5_old_ip_match", 32'(last_match), 32'h1);
    send_pkt(2, 32'hC0A80001, 32'h0A000001, 0, -1, -1, 0, 1'b0, -1, t);
    chk("p6_new_ip_match", 32'(last_match), 32'h1);
    send_pkt(1, 32'hC0A80001, 0, 0, -1, -1, 0, 1'b0, -1, t);
    chk("p7_old_ip_gone", 32'(last_match), 32'h0);
    send_pkt(2, 32'h12C0A800, 32'h01343434, 0, -1, -1, 32'hC0A80001, 1'b1, -1, t);
    chk("p8_coincident_wr", 32'(last_match), 32'h1);
    chk("p8_count", 32'(match_count), 32'd5);

    step();
    force dut.u_cnt.count_q = 16'hFFFC;
    model_cnt = 16'hFFFC;
    step();
    step();
    release dut.u_cnt.count_q;
    for (int i = 0; i < 4; i++)
      send_pkt(1, 32'hC0A80001, 0, 0, -1, -1, 0, 1'b0, -1, t);
    chk("sat_count", 32'(match_count), 32'h0000FFFF);

    step();
    cfg_enable = 1'b1; pkt_start = 1'b1; exp_accept = 1'b1;
    busy_from = cyc + 1; busy_to = cyc + 1000;
    step();
    exp_ip = exp_shadow;
    pkt_valid = 1'b1; pkt_data = 32'hC0A80001; exp_data = 32'hC0A80001;
    step();
    rst = 1'b1; pkt_valid = 1'b1; pkt_data = 32'h55555555;
    busy_to = cyc - 1; exp_rv_cyc = -1; model_cnt = 0; exp_ip = '0; exp_shadow = '0;
    @(negedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_clear", 32'(cmp_clear), 32'h1);
    chk("midrst_valid", 32'(result_valid), 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("post_rst_no_result", 32'(last_rv_cyc < t + 10), 32'h1);

    cfg_write(32'hC0A80001);
    send_pkt(3, 32'h11111111, 32'hC0A80001, 32'h22222222, -1, -1, 0, 1'b0, -1, t);
    chk("post_rst_count", 32'(match_count), 32'd1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
